// File: rtl/pll_lock_mgr_pkg.sv
// Shared state type and counter-width helper for the PLL lock manager.
package pll_lock_mgr_pkg;

  typedef enum logic [2:0] {PULSE, WAIT, FILT, RELEASE, RUN, FAIL} state_t;

  function automatic int cnt_w(input int max_val);
    return $clog2(max_val) + 1;
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchroniser for the asynchronous PLL lock indication, resets to 0.
module pll_lock_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_mgr.sv
// PLL reset/lock sequencer: pulses pll_rst, filters lock, releases user_rst, retries then fails.
// Optional lock_loss_cnt output when PLL_LOCK_MGR_LOSS_CNT_EN is defined.
//   state   | meaning
//   PULSE   | pll_rst held high
//   WAIT    | waiting for synced lock, timeout running
//   FILT    | counting consecutive synced-lock cycles
//   RELEASE | locked, user_rst still held
//   RUN     | user_rst released
//   FAIL    | retries exhausted, sticky until sys_rst
module pll_lock_mgr
  import pll_lock_mgr_pkg::*;
#(
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_TIMEOUT_CYC = 125000,
  parameter int LOCK_FILT_CYC    = 256,
  parameter int RELEASE_DLY_CYC  = 64,
  parameter int RETRY_MAX        = 3,
  localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1
) (
  input  logic          clkin1,
  input  logic          sys_rst,
  input  logic          pll_lock,
  output logic          pll_rst,
  output logic          user_rst,
  output logic          locked,
  output logic          fail,
  output logic [RW-1:0] retry_cnt
`ifdef PLL_LOCK_MGR_LOSS_CNT_EN
  ,
  output logic [7:0]    lock_loss_cnt
`endif
);

  localparam int MAX_A = (RST_PULSE_CYC > LOCK_FILT_CYC) ? RST_PULSE_CYC : LOCK_FILT_CYC;
  localparam int MAX_B = (LOCK_TIMEOUT_CYC > RELEASE_DLY_CYC) ? LOCK_TIMEOUT_CYC : RELEASE_DLY_CYC;
  localparam int CW    = cnt_w((MAX_A > MAX_B) ? MAX_A : MAX_B);

  localparam logic [CW-1:0] PULSE_TC  = CW'(RST_PULSE_CYC - 1);
  localparam logic [CW-1:0] TMO_TC    = CW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] REL_TC    = CW'(RELEASE_DLY_CYC - 1);
  // The WAIT cycle that first sees lock counts as the first filter sample.
  localparam logic [CW-1:0] FILT_TC   = CW'((LOCK_FILT_CYC >= 2) ? LOCK_FILT_CYC - 2 : 0);
  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [RW-1:0] RETRY_LIM = RW'(RETRY_MAX);

  state_t          state, nxt;
  logic [CW-1:0]   cnt, tmo;
  logic [RW-1:0]   retry_nxt;
  logic            lock_s, accept, timeout, tmo_run;

  pll_lock_sync u_lock_sync (
    .clk (clkin1),
    .rst (sys_rst),
    .d   (pll_lock),
    .q   (lock_s)
  );

  always_comb begin
    nxt       = state;
    retry_nxt = retry_cnt;
    timeout   = (tmo >= TMO_TC);
    accept    = lock_s && ((state == FILT) ? (cnt >= FILT_TC) : (LOCK_FILT_CYC == 1));
    case (state)
      PULSE: if (cnt >= PULSE_TC) nxt = WAIT;
      WAIT, FILT: begin
        if (accept) begin
          nxt = RELEASE;
        end else if (timeout) begin
          if (retry_cnt < RETRY_LIM) begin
            nxt       = PULSE;
            retry_nxt = retry_cnt + RW'(1);
          end else begin
            nxt = FAIL;
          end
        end else if (lock_s) begin
          nxt = FILT;
        end else begin
          nxt = WAIT;
        end
      end
      RELEASE: begin
        if (!lock_s) begin
          nxt = PULSE;
        end else if (cnt >= REL_TC) begin
          nxt       = RUN;
          retry_nxt = '0;
        end
      end
      RUN:     if (!lock_s) nxt = PULSE;
      FAIL:    nxt = FAIL;
      default: nxt = PULSE;
    endcase
  end

  assign tmo_run = (state == WAIT || state == FILT) && (nxt == WAIT || nxt == FILT);

  always_ff @(posedge clkin1 or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= PULSE;
      cnt       <= '0;
      tmo       <= '0;
      retry_cnt <= '0;
      pll_rst   <= 1'b1;
      user_rst  <= 1'b1;
      locked    <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state     <= nxt;
      cnt       <= (nxt != state) ? '0 : ((cnt == CNT_MAX) ? cnt : cnt + 1'b1);
      tmo       <= !tmo_run ? '0 : ((tmo >= TMO_TC) ? tmo : tmo + 1'b1);
      retry_cnt <= retry_nxt;
      pll_rst   <= (nxt == PULSE);
      user_rst  <= (nxt != RUN);
      locked    <= (nxt == RELEASE) || (nxt == RUN);
      fail      <= (nxt == FAIL);
    end
  end

`ifdef PLL_LOCK_MGR_LOSS_CNT_EN
  logic loss;
  assign loss = (state == RELEASE || state == RUN) && !lock_s;

  always_ff @(posedge clkin1 or posedge sys_rst) begin
    if (sys_rst)
      lock_loss_cnt <= '0;
    else if (loss && lock_loss_cnt != 8'hFF)
      lock_loss_cnt <= lock_loss_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_pll_lock_mgr.sv
// Self-checking bench for pll_lock_mgr: randomized lock timing against expected latencies.
module tb_pll_lock_mgr;

  localparam int P_PULSE  = 4;
  localparam int P_TMO    = 100;
  localparam int P_FILT   = 8;
  localparam int P_REL    = 5;
  localparam int P_RETRY  = 2;
  localparam int SYNC_LAT = 2;

  localparam int S_PLL_RST  = 0;
  localparam int S_USER_RST = 1;
  localparam int S_LOCKED   = 2;
  localparam int S_FAIL     = 3;

  logic       clkin1   = 1'b0;
  logic       sys_rst  = 1'b1;
  logic       pll_lock = 1'b0;
  logic       pll_rst, user_rst, locked, fail;
  logic [1:0] retry_cnt;
`ifdef PLL_LOCK_MGR_LOSS_CNT_EN
  logic [7:0] lock_loss_cnt;
`endif

  int cyc   = 0;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clkin1 = ~clkin1;
  always @(posedge clkin1) cyc <= cyc + 1;

  pll_lock_mgr #(
    .RST_PULSE_CYC    (P_PULSE),
    .LOCK_TIMEOUT_CYC (P_TMO),
    .LOCK_FILT_CYC    (P_FILT),
    .RELEASE_DLY_CYC  (P_REL),
    .RETRY_MAX        (P_RETRY)
  ) dut (
    .clkin1        (clkin1),
    .sys_rst       (sys_rst),
    .pll_lock      (pll_lock),
    .pll_rst       (pll_rst),
    .user_rst      (user_rst),
    .locked        (locked),
    .fail          (fail),
    .retry_cnt     (retry_cnt)
`ifdef PLL_LOCK_MGR_LOSS_CNT_EN
    ,
    .lock_loss_cnt (lock_loss_cnt)
`endif
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      S_PLL_RST:  return pll_rst;
      S_USER_RST: return user_rst;
      S_LOCKED:   return locked;
      S_FAIL:     return fail;
      default:    return 1'b0;
    endcase
  endfunction

  // Returns the edge number at which the signal first reaches val, or -1.
  task automatic wait_sig(input int sel, input logic val, input int limit, output int t);
    t = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clkin1);
      if (sig(sel) === val) begin
        t = cyc;
        return;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clkin1);
  endtask

  task automatic do_reset(output int r);
    @(negedge clkin1);
    sys_rst  = 1'b1;
    pll_lock = 1'b0;
    idle(2);
    sys_rst = 1'b0;
    r = cyc;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pll_rst"},  pll_rst,   1);
    chk({tag, "_user_rst"}, user_rst,  1);
    chk({tag, "_locked"},   locked,    0);
    chk({tag, "_fail"},     fail,      0);
    chk({tag, "_retry"},    retry_cnt, 0);
  endtask

  // Raise lock after a random delay and check filter and release latencies.
  task automatic lock_and_run(input string tag, input int dmax);
    int l0, t_lk, t_ur;
    idle($urandom_range(dmax, 1));
    l0 = cyc;
    pll_lock = 1'b1;
    wait_sig(S_LOCKED, 1'b1, 200, t_lk);
    chk({tag, "_lock_lat"}, t_lk - l0, SYNC_LAT + P_FILT);
    chk({tag, "_urst_in_rel"}, user_rst, 1);
    wait_sig(S_USER_RST, 1'b0, 50, t_ur);
    chk({tag, "_rel_dly"}, t_ur - t_lk, P_REL);
    chk({tag, "_run_retry"}, retry_cnt, 0);
  endtask

  initial begin
    #200_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int r, t, t2, l0, d0;

    @(negedge clkin1);
    chk_reset_vals("por");
    sys_rst = 1'b0;

    // Nominal bring-up followed by lock loss in RUN
    for (int it = 0; it < 3; it++) begin
      do_reset(r);
      wait_sig(S_PLL_RST, 1'b0, 20, t);
      chk("nom_pulse_len", t - r, P_PULSE);
      lock_and_run("nom", 80);
      idle($urandom_range(20, 1));
      d0 = cyc;
      pll_lock = 1'b0;
      wait_sig(S_LOCKED, 1'b0, 10, t);
      chk("loss_lat", t - d0, SYNC_LAT + 1);
      chk("loss_user_rst", user_rst, 1);
      chk("loss_pll_rst", pll_rst, 1);
      wait_sig(S_PLL_RST, 1'b0, 20, t2);
      chk("loss_pulse_len", t2 - t, P_PULSE);
      lock_and_run("relock", 60);
    end

    // Short lock glitch must restart the filter
    for (int it = 0; it < 3; it++) begin
      do_reset(r);
      wait_sig(S_PLL_RST, 1'b0, 20, t);
      idle($urandom_range(30, 1));
      pll_lock = 1'b1;
      idle($urandom_range(P_FILT - 1, 1));
      pll_lock = 1'b0;
      idle($urandom_range(10, 1));
      l0 = cyc;
      pll_lock = 1'b1;
      wait_sig(S_LOCKED, 1'b1, 200, t);
      chk("glitch_lock_lat", t - l0, SYNC_LAT + P_FILT);
    end

    // One timeout, then lock loss during RELEASE keeps retry_cnt
    do_reset(r);
    wait_sig(S_PLL_RST, 1'b0, 20, t);
    wait_sig(S_PLL_RST, 1'b1, 200, t2);
    chk("rel_tmo_period", t2 - t, P_TMO);
    chk("rel_tmo_retry", retry_cnt, 1);
    wait_sig(S_PLL_RST, 1'b0, 20, t);
    idle($urandom_range(40, 1));
    l0 = cyc;
    pll_lock = 1'b1;
    wait_sig(S_LOCKED, 1'b1, 200, t);
    chk("rel_lock_lat", t - l0, SYNC_LAT + P_FILT);
    idle($urandom_range(2, 0));
    d0 = cyc;
    pll_lock = 1'b0;
    wait_sig(S_LOCKED, 1'b0, 10, t);
    chk("rel_loss_lat", t - d0, SYNC_LAT + 1);
    chk("rel_loss_retry", retry_cnt, 1);
    chk("rel_loss_user_rst", user_rst, 1);
    wait_sig(S_PLL_RST, 1'b0, 20, t);
    lock_and_run("rel_relock", 60);

    // Lock never arrives: retries then FAIL
    do_reset(r);
    wait_sig(S_PLL_RST, 1'b0, 20, t);
    chk("tmo_first_pulse", t - r, P_PULSE);
    for (int a = 1; a <= P_RETRY; a++) begin
      wait_sig(S_PLL_RST, 1'b1, 200, t2);
      chk("tmo_period", t2 - t, P_TMO);
      chk("tmo_retry", retry_cnt, a);
      wait_sig(S_PLL_RST, 1'b0, 20, t);
      chk("tmo_pulse_len", t - t2, P_PULSE);
    end
    wait_sig(S_FAIL, 1'b1, 200, t2);
    chk("fail_time", t2 - t, P_TMO);
    idle(150);
    chk("fail_sticky", fail, 1);
    chk("fail_pll_rst", pll_rst, 0);
    chk("fail_user_rst", user_rst, 1);
    chk("fail_locked", locked, 0);

    // Asynchronous reset in FAIL and mid-FILT
    @(negedge clkin1);
    #2 sys_rst = 1'b1;
    #1 chk_reset_vals("rst_in_fail");
    @(negedge clkin1);
    sys_rst = 1'b0;
    r = cyc;
    wait_sig(S_PLL_RST, 1'b0, 20, t);
    chk("restart_pulse_len", t - r, P_PULSE);
    idle(3);
    pll_lock = 1'b1;
    idle(5);
    #2 sys_rst = 1'b1;
    #1 chk_reset_vals("rst_in_filt");
    @(negedge clkin1);
    sys_rst = 1'b0;
    r = cyc;
    wait_sig(S_PLL_RST, 1'b0, 20, t);
    chk("filt_restart_pulse", t - r, P_PULSE);
    wait_sig(S_LOCKED, 1'b1, 200, t2);
    chk("filt_restart_lock", t2 - t, P_FILT);
    wait_sig(S_USER_RST, 1'b0, 50, t);
    chk("filt_restart_rel", t - t2, P_REL);

`ifdef PLL_LOCK_MGR_LOSS_CNT_EN
    do_reset(r);
    chk("loss_cnt_reset", lock_loss_cnt, 0);
    for (int n = 1; n <= 300; n++) begin
      wait_sig(S_PLL_RST, 1'b0, 20, t);
      pll_lock = 1'b1;
      wait_sig(S_LOCKED, 1'b1, 200, t);
      pll_lock = 1'b0;
      wait_sig(S_LOCKED, 1'b0, 10, t);
      if (n == 1 || n == 254 || n == 255 || n == 300)
        chk("loss_cnt", lock_loss_cnt, (n > 255) ? 255 : n);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
